// File: rtl/disp_share_arbiter.sv
// rtl/disp_share_arbiter.sv - round-robin arbiter sharing one 7-segment display driver (option: DISP_ARB_PREEMPT_EN)
module disp_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*16-1:0]         bcd_in,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
    output logic [15:0]                   bcd_out,
    output logic                          disp_en
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state;
    logic [IDW-1:0]     last;
    logic [CW-1:0]      hold_cnt;
    logic [NUM_REQ-1:0] others;
    logic [IDW-1:0]     pick;
    logic [IDW-1:0]     target;
    logic               do_grant;
    logic               go_idle;

    // First set bit of m scanning upward from (from+1) with wrap; the start
    // point itself is checked last, so it only wins when it is alone.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] m,
                                               input logic [IDW-1:0]     from);
        logic [IDW-1:0] sel;
        logic           found;
        int             j;
        sel   = from;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(from) + k) % NUM_REQ;
            if (!found && m[j]) begin
                found = 1'b1;
                sel   = IDW'(j);
            end
        end
        return sel;
    endfunction

    // Competitors exclude the current winner; in IDLE gnt is zero so this is req.
    assign others = req & ~gnt;
    assign pick   = rr_pick(others, last);

    // Decide this cycle's action: new grant (with its target), drop to idle, or stay.
    always_comb begin
        do_grant = 1'b0;
        go_idle  = 1'b0;
        target   = pick;
        case (state)
            IDLE: do_grant = |req;
            GRANT: begin
`ifdef DISP_ARB_PREEMPT_EN
                if (req[0] && gnt_id != '0) begin
                    do_grant = 1'b1;
                    target   = '0;
                end else
`endif
                if (!req[gnt_id]) begin
                    if (|others) do_grant = 1'b1;
                    else         go_idle  = 1'b1;
                end else if (hold_cnt == HOLD_MAX && |others
`ifdef DISP_ARB_PREEMPT_EN
                             && gnt_id != '0
`endif
                            ) begin
                    do_grant = 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase
    end

    // Registered grant state, display outputs and hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            last     <= IDW'(NUM_REQ - 1);
            bcd_out  <= 16'h0000;
            disp_en  <= 1'b0;
            hold_cnt <= '0;
        end else if (do_grant) begin
            state    <= GRANT;
            gnt      <= NUM_REQ'(1) << target;
            gnt_id   <= target;
            last     <= target;
            bcd_out  <= bcd_in[int'(target)*16 +: 16];
            disp_en  <= 1'b1;
            hold_cnt <= '0;
        end else if (go_idle) begin
            state    <= IDLE;
            gnt      <= '0;
            disp_en  <= 1'b0;
            hold_cnt <= '0;
        end else if (state == GRANT) begin
            bcd_out <= bcd_in[int'(gnt_id)*16 +: 16];
            if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_disp_share_arbiter.sv
// tb/tb_disp_share_arbiter.sv - directed self-checking bench for disp_share_arbiter
module tb_disp_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] bcd_in;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic [15:0] bcd_out;
    logic        disp_en;

    int n_total = 0;
    int n_bad   = 0;

    disp_share_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .bcd_in  (bcd_in),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .bcd_out (bcd_out),
        .disp_en (disp_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [3:0] rot_exp [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};

    initial begin
        rst    = 1'b1;
        req    = 4'b0000;
        bcd_in = 64'h0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_gnt", {28'h0, gnt}, 32'h0);
        chk("rst_gnt_id", {30'h0, gnt_id}, 32'h0);
        chk("rst_bcd", {16'h0, bcd_out}, 32'h0);
        chk("rst_en", {31'h0, disp_en}, 32'h0);

        // single request on requester 2
        bcd_in[47:32] = 16'h1234;
        req = 4'b0100;
        tick();
        chk("single_gnt", {28'h0, gnt}, 32'h4);
        chk("single_id", {30'h0, gnt_id}, 32'h2);
        chk("single_bcd", {16'h0, bcd_out}, 32'h1234);
        chk("single_en", {31'h0, disp_en}, 32'h1);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("single_hold", {28'h0, gnt}, 32'h4);
        end

        // asynchronous reset mid-grant
        rst = 1'b1;
        req = 4'b0000;
        #1;
        chk("arst_gnt", {28'h0, gnt}, 32'h0);
        chk("arst_en", {31'h0, disp_en}, 32'h0);
        chk("arst_bcd", {16'h0, bcd_out}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("idle_stay", {28'h0, gnt}, 32'h0);

        // rotation 0 -> 1 -> 3 -> 0, 4 cycles each
        rst = 1'b1;
        req = 4'b1011;
        tick();
        rst = 1'b0;
        tick();
        for (int c = 0; c < 16; c++) begin
            chk("rot_gnt", {28'h0, gnt}, {28'h0, rot_exp[c/4]});
            chk("rot_en", {31'h0, disp_en}, 32'h1);
            tick();
        end

        // release with handover, hold restarts
        do_reset();
        req = 4'b0110;
        tick();
        chk("ho_first", {28'h0, gnt}, 32'h2);
        tick();
        req = 4'b0100;
        tick();
        chk("ho_gnt", {28'h0, gnt}, 32'h4);
        chk("ho_id", {30'h0, gnt_id}, 32'h2);
        req = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("ho_hold", {28'h0, gnt}, 32'h4);
        end
        tick();
        chk("ho_rotate", {28'h0, gnt}, 32'h2);

        // live update then release to idle
        do_reset();
        bcd_in[63:48] = 16'h0001;
        req = 4'b1000;
        tick();
        chk("live_gnt", {28'h0, gnt}, 32'h8);
        chk("live_bcd1", {16'h0, bcd_out}, 32'h0001);
        bcd_in[63:48] = 16'h0002;
        tick();
        chk("live_bcd2", {16'h0, bcd_out}, 32'h0002);
        req = 4'b0000;
        tick();
        chk("rel_gnt", {28'h0, gnt}, 32'h0);
        chk("rel_en", {31'h0, disp_en}, 32'h0);
        chk("rel_bcd", {16'h0, bcd_out}, 32'h0002);
        chk("rel_id", {30'h0, gnt_id}, 32'h3);

`ifdef DISP_ARB_PREEMPT_EN
        // requester 0 preempts requester 2
        do_reset();
        req = 4'b0100;
        tick();
        chk("pre_first", {28'h0, gnt}, 32'h4);
        tick();
        req = 4'b0101;
        tick();
        chk("pre_gnt", {28'h0, gnt}, 32'h1);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("pre_hold", {28'h0, gnt}, 32'h1);
        end
        req = 4'b0100;
        tick();
        chk("pre_back", {28'h0, gnt}, 32'h4);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/disp_share_arbiter.md
Name: disp_share_arbiter

Overview:
- Round-robin arbiter sharing the single 4-digit 7-segment display driver between NUM_REQ independent requesters.
- Each requester presents a 16-bit packed BCD word plus a request line.
- The arbiter grants one requester at a time, enforces a minimum on-screen hold time before rotating, and drives the BCD word and a display-enable into the display driver.
- Sits between application logic and the 7-segment driver in the board top level.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- HOLD_CYCLES, 100_000_000, minimum clk cycles a grant is held while other requests are pending (1 s at 100 MHz); must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  per-requester request level; bit i belongs to requester i.
- bcd_in  in  NUM_REQ*16  packed BCD words; requester i uses bcd_in[16*i +: 16], digit order as expected by the display driver.
- gnt  out  NUM_REQ  one-hot grant, or all-zero when idle.
- gnt_id  out  $clog2(NUM_REQ)  index of the current/last granted requester.
- bcd_out  out  16  BCD word forwarded to the display driver.
- disp_en  out  1  high while a grant is active; low means blank the display.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, immediate, including mid-operation):
  - state=IDLE, gnt=0, gnt_id=0, bcd_out=16'h0000, disp_en=0, hold_cnt=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority after reset.
- Round-robin pick: first i with req[i]=1, scanning from (last+1) mod NUM_REQ upward with wrap.
- IDLE:
  - If req is nonzero in cycle k, then at cycle k+1: state=GRANT, gnt one-hot at the pick, gnt_id=pick, last=pick, bcd_out=bcd_in word of the pick (sampled at k), disp_en=1, hold_cnt=0.
  - Latency from req to gnt/display is 1 cycle.
- GRANT, each cycle, priority order:
  1. Release: req[gnt_id]=0.
     - If another req is pending: switch to the round-robin pick next cycle, with no blank gap and hold_cnt=0.
     - Else: go to IDLE next cycle with gnt=0 and disp_en=0; bcd_out keeps its last value; gnt_id unchanged.
  2. Rotate: hold_cnt==HOLD_CYCLES-1 and any other req pending → switch to the round-robin pick starting after gnt_id; hold_cnt=0.
  3. Stay:
     - bcd_out <= bcd_in word of gnt_id, so live updates are visible 1 cycle later.
     - hold_cnt increments, saturating at HOLD_CYCLES-1.
     - If no competitor is present, the grant persists indefinitely.
- The winner is always excluded from its own rotation candidate scan. It can only be re-granted by wrap-around after all others are scanned, i.e. when it is the only requester.
- hold_cnt width: $clog2(HOLD_CYCLES+1). With HOLD_CYCLES=1, rotation can occur every cycle under contention.
- Simultaneous release of the granted requester and new requests are resolved by the same round-robin pick.
- bcd_out is passed through without validation; BCD contents are not checked.
- gnt is never multi-hot. disp_en==|gnt at all times.

Optional Feature:
- Macro: DISP_ARB_PREEMPT_EN.
- Defined:
  - Requester 0 is high priority.
  - If req[0]=1 while another requester is granted, the grant switches to 0 next cycle regardless of hold_cnt (hold_cnt=0, last=0).
  - While 0 is granted and req[0]=1, hold expiry never rotates away.
  - On release of 0, normal round-robin resumes from last=0.
- Undefined: requester 0 is an ordinary round-robin participant; no preemption logic is synthesised.

Test Plan:
All scenarios use NUM_REQ=4, HOLD_CYCLES=4.
- Reset/idle:
  - Stimulus: rst pulse mid-grant, req=0.
  - Response: gnt=0, disp_en=0, bcd_out=0 immediately (asynchronous); stays idle; no grant.
- Single request:
  - Stimulus: req=4'b0100, bcd_in[47:32]=16'h1234 at cycle k.
  - Response: at k+1 gnt=4'b0100, gnt_id=2, bcd_out=16'h1234, disp_en=1; grant held for 20 cycles with no rotation.
- Rotation:
  - Stimulus: req=4'b1011 held from reset.
  - Response: grants 0→1→3→0; each grant lasts exactly 4 cycles; no idle cycle between grants.
- Release with handover:
  - Stimulus: requester 1 granted, req changes 4'b0110→4'b0100 at cycle 1 of hold.
  - Response: gnt=4'b0100 next cycle, hold_cnt restarts.
- Release to idle and live update:
  - Stimulus: granted requester 3 changes its word 16'h0001→16'h0002, then drops req.
  - Response: bcd_out shows 16'h0002 one cycle after the change; after the drop, gnt=0, disp_en=0 and bcd_out stays 16'h0002.
- Preempt (DISP_ARB_PREEMPT_EN defined):
  - Stimulus: requester 2 granted at hold_cnt=1, then req[0] asserts.
  - Response: gnt=4'b0001 next cycle; held past 4 cycles despite req[2]=1; on req[0] drop, gnt goes to 2.
